tt_mux_sel_sequencer: RTL and testbench



---
 rtl/tt_mux_sel_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_tt_mux_sel_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_mux_sel_sequencer.sv
// Runtime select-chain sequencer: walks the project-mux chain to a requested address.
// Optional forward-stepping without chain reset is compiled in with TT_MUXSEQ_FAST_FWD_EN.
module tt_mux_sel_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int INC_HIGH   = 1,
  parameter int INC_LOW    = 1,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              dis_req,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  // Handshake: a request is taken on a clock edge where req_valid and req_ready
  // are both high; req_ready is only high in IDLE/ACTIVE, other requests are dropped.

`ifdef TT_MUXSEQ_FAST_FWD_EN
  localparam bit FAST_FWD = 1'b1;
`else
  localparam bit FAST_FWD = 1'b0;
`endif

  localparam int MAX_HL = (INC_HIGH > INC_LOW) ? INC_HIGH : INC_LOW;
  localparam int MAX_C  = (MAX_HL > RST_CYCLES) ? MAX_HL : RST_CYCLES;
  localparam int TW     = $clog2(MAX_C + 1);

  localparam logic [TW-1:0] T_HI  = TW'(INC_HIGH - 1);
  localparam logic [TW-1:0] T_LO  = TW'(INC_LOW - 1);
  localparam logic [TW-1:0] T_RST = TW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_DISABLE,
    S_CHAIN_RST,
    S_STEP_HI,
    S_STEP_LO
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              cur_valid_q, cur_valid_d;
  logic              rst_n_q, rst_n_d;
  logic              inc_q, inc_d;
  logic              ena_q, ena_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  logic accept;
  logic fast_ok;

  assign accept  = req_valid & ready_q;
  assign fast_ok = FAST_FWD & cur_valid_q & (req_addr >= cur_addr_q);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    target_d    = target_q;
    cur_addr_d  = cur_addr_q;
    cur_valid_d = cur_valid_q;
    if (timer_q != '0) timer_d = timer_q - TW'(1);

    case (state_q)
      S_IDLE, S_ACTIVE: begin
        // An accepted request overrides a simultaneous disable pulse.
        if (accept) begin
          target_d = req_addr;
          if (fast_ok) begin
            state_d = S_DISABLE;
          end else begin
            state_d     = S_CHAIN_RST;
            timer_d     = T_RST;
            cur_valid_d = 1'b0;
          end
        end else if (state_q == S_ACTIVE && dis_req) begin
          state_d = S_IDLE;
        end
      end
      S_DISABLE: begin
        if (cur_addr_q == target_q) begin
          state_d = S_ACTIVE;
        end else begin
          state_d = S_STEP_HI;
          timer_d = T_HI;
        end
      end
      S_CHAIN_RST: begin
        if (timer_q == '0) begin
          cur_addr_d  = '0;
          cur_valid_d = 1'b1;
          if (target_q == '0) begin
            state_d = S_ACTIVE;
          end else begin
            state_d = S_STEP_HI;
            timer_d = T_HI;
          end
        end
      end
      S_STEP_HI: begin
        if (timer_q == '0) begin
          state_d    = S_STEP_LO;
          timer_d    = T_LO;
          cur_addr_d = cur_addr_q + ADDR_W'(1);
        end
      end
      S_STEP_LO: begin
        if (timer_q == '0) begin
          if (cur_addr_q == target_q) begin
            state_d = S_ACTIVE;
          end else begin
            state_d = S_STEP_HI;
            timer_d = T_HI;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of functions of the next state.
    ena_d   = (state_d == S_ACTIVE);
    done_d  = (state_d == S_ACTIVE) && (state_q != S_ACTIVE);
    busy_d  = !((state_d == S_IDLE) || (state_d == S_ACTIVE));
    ready_d = !busy_d;
    inc_d   = (state_d == S_STEP_HI);
    if (state_d == S_CHAIN_RST)      rst_n_d = 1'b0;
    else if (state_q == S_CHAIN_RST) rst_n_d = 1'b1;
    else                             rst_n_d = rst_n_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      target_q    <= '0;
      cur_addr_q  <= '0;
      cur_valid_q <= 1'b0;
      rst_n_q     <= 1'b0;
      inc_q       <= 1'b0;
      ena_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      target_q    <= target_d;
      cur_addr_q  <= cur_addr_d;
      cur_valid_q <= cur_valid_d;
      rst_n_q     <= rst_n_d;
      inc_q       <= inc_d;
      ena_q       <= ena_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign req_ready      = ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign cur_addr       = cur_addr_q;
  assign cur_valid      = cur_valid_q;
  assign ctrl_sel_rst_n = rst_n_q;
  assign ctrl_sel_inc   = inc_q;
  assign ctrl_ena       = ena_q;

endmodule

// File: tb/tb_tt_mux_sel_sequencer.sv
// Bench for tt_mux_sel_sequencer: directed requests, expected selection records
// queued at issue and checked by a monitor on each done pulse.
module tb_tt_mux_sel_sequencer;

`ifdef TT_MUXSEQ_FAST_FWD_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam int W = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [9:0] req_addr = '0;
  logic       dis_req = 1'b0;
  logic       req_ready, busy, done, cur_valid;
  logic       ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;
  logic [9:0] cur_addr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  tt_mux_sel_sequencer #(
    .ADDR_W(10), .INC_HIGH(1), .INC_LOW(1), .RST_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .dis_req(dis_req), .busy(busy), .done(done),
    .cur_addr(cur_addr), .cur_valid(cur_valid),
    .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Record: {latency, cur_addr, inc pulses, rst_n low cycles, ena at T+1, ena at done}
  function automatic logic [W-1:0] mk_exp(input int lat, input int addr, input int inc, input int rl);
    return {12'(lat), 10'(addr), 8'(inc), 8'(rl), 1'b0, 1'b1};
  endfunction

  // outputs packed as {rst_n, inc, ena, busy, done, ready, cur_valid, cur_addr}
  function automatic logic [16:0] out_vec();
    return {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, busy, done, req_ready, cur_valid, cur_addr};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int   cyc = 0;
  int   acc_cyc = -100;
  int   inc_cnt = 0;
  int   rl_cnt = 0;
  logic inc_prev = 1'b0;
  logic ena_t1 = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] act, expv;
    cyc++;
    if (cyc == acc_cyc + 1) ena_t1 = ctrl_ena;
    if (ctrl_sel_inc && !inc_prev) inc_cnt++;
    inc_prev = ctrl_sel_inc;
    if (!ctrl_sel_rst_n) rl_cnt++;
    if (done) begin
      act = {12'(cyc - acc_cyc), cur_addr, 8'(inc_cnt), 8'(rl_cnt), ena_t1, ctrl_ena};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: actual=0x%0h expected=no selection", act);
      end else begin
        expv = exp_q.pop_front();
        check("selection", 64'(act), 64'(expv));
      end
    end
    if (req_valid && req_ready && !rst) begin
      acc_cyc = cyc;
      inc_cnt = 0;
      rl_cnt  = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    check("reset_outputs", 64'(out_vec()), 64'(17'b0_0_0_0_0_1_0_0000000000));
    rst = 1'b0;
  endtask

  task automatic send(input int addr, input logic dis, input logic push, input logic [W-1:0] e);
    int guard;
    guard = 0;
    while (!req_ready && guard < 100) begin
      tick();
      guard++;
    end
    check("ready_before_send", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_addr  = 10'(addr);
    dis_req   = dis;
    if (push) exp_q.push_back(e);
    tick();
    req_valid = 1'b0;
    dis_req   = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 80; i++) begin
      if (done) break;
      tick();
    end
    if (i == 80) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: actual=no done expected=done within 80 cycles");
    end
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) tick();
    do_reset();

    // N=0 from reset: 2 rst_n low cycles, enable at T+3
    send(0, 1'b0, 1'b1, mk_exp(3, 0, 0, 2));
    wait_done();

    do_reset();
    send(5, 1'b0, 1'b1, mk_exp(13, 5, 5, 2));
    wait_done();

    send(7, 1'b0, 1'b1, FAST ? mk_exp(6, 7, 2, 0) : mk_exp(17, 7, 7, 2));
    wait_done();

    // backwards always resets the chain
    send(3, 1'b0, 1'b1, mk_exp(9, 3, 3, 2));
    wait_done();

    // same address again: enable must still drop for a cycle
    send(3, 1'b0, 1'b1, FAST ? mk_exp(2, 3, 0, 0) : mk_exp(9, 3, 3, 2));
    wait_done();

    // disable from ACTIVE keeps position
    tick();
    dis_req = 1'b1;
    tick();
    dis_req = 1'b0;
    check("dis_ena", 64'(ctrl_ena), 64'(0));
    check("dis_ready", 64'(req_ready), 64'(1));
    check("dis_busy", 64'(busy), 64'(0));
    check("dis_pos", 64'({cur_valid, cur_addr}), 64'({1'b1, 10'd3}));

    // request during busy is ignored
    send(4, 1'b0, 1'b1, FAST ? mk_exp(4, 4, 1, 0) : mk_exp(11, 4, 4, 2));
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_addr  = 10'd5;
      check("busy_ready", 64'(req_ready), 64'(0));
      tick();
    end
    req_valid = 1'b0;
    wait_done();
    check("busy_final_addr", 64'(cur_addr), 64'(4));

    // request and dis_req together: request wins
    send(6, 1'b1, 1'b1, FAST ? mk_exp(6, 6, 2, 0) : mk_exp(15, 6, 6, 2));
    wait_done();

    // reset in the middle of a step
    send(9, 1'b0, 1'b0, '0);
    begin
      int g;
      for (g = 0; g < 40; g++) begin
        if (ctrl_sel_inc) break;
        tick();
      end
      check("saw_step_hi", 64'(ctrl_sel_inc), 64'(1));
    end
    rst = 1'b1;
    tick();
    check("midrst_outputs", 64'(out_vec()), 64'(17'b0_0_0_0_0_1_0_0000000000));
    rst = 1'b0;

    send(2, 1'b0, 1'b1, mk_exp(7, 2, 2, 2));
    wait_done();

    repeat (3) tick();
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
